// File: rtl/safe_input_arbiter_if.sv
// Symbol bus between N_REQ keypad front-ends and the safe controller input port.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface safe_input_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 4
);
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]       data_in_o;
  logic                    data_in_valid_o;
  logic                    data_in_ready_i;

  modport slave (
    input  req_data_i, req_valid_i, req_last_i, data_in_ready_i,
    output req_ready_o, data_in_o, data_in_valid_o
  );

  modport master (
    output req_data_i, req_valid_i, req_last_i, data_in_ready_i,
    input  req_ready_o, data_in_o, data_in_valid_o
  );
endinterface

// File: rtl/safe_input_arbiter.sv
// Session-based round-robin arbiter: one keypad source owns the safe's symbol port until
// a last beat or an idle timeout. 1-cycle grant latency, then zero-latency pass-through.
module safe_input_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = 4,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  safe_input_arbiter_if.slave  bus,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int OWN_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  if (N_REQ < 2) begin : g_bad_n_req
    $error("safe_input_arbiter: N_REQ must be >= 2");
  end
  if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
    $error("safe_input_arbiter: IDLE_TIMEOUT must be >= 2");
  end

  typedef enum logic {S_IDLE, S_OWNED} state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [OWN_W-1:0]   pick;
  logic               found;
  logic               hs;
  int                 idx;

  // Round-robin search starting just after the last session owner.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && bus.req_valid_i[idx]) begin
        found = 1'b1;
        pick  = OWN_W'(idx);
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    rr_d                = rr_q;
    cnt_d               = cnt_q;
    timeout_d           = 1'b0;
    grant_o             = '0;
    busy_o              = 1'b0;
    bus.req_ready_o     = '0;
    bus.data_in_o       = '0;
    bus.data_in_valid_o = 1'b0;
    hs                  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = S_OWNED;
        end
      end
      S_OWNED: begin
        busy_o                   = 1'b1;
        grant_o[owner_q]         = 1'b1;
        bus.data_in_o            = bus.req_data_i[int'(owner_q)*DATA_W +: DATA_W];
        bus.data_in_valid_o      = bus.req_valid_i[owner_q];
        bus.req_ready_o[owner_q] = bus.data_in_ready_i;
        hs = bus.req_valid_i[owner_q] & bus.data_in_ready_i;

        // A handshake on the final idle cycle keeps the session alive.
        if (hs) begin
          cnt_d = '0;
          if (bus.req_last_i[owner_q]) begin
            rr_d    = owner_q;
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          rr_d      = owner_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= OWN_W'(N_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_safe_input_arbiter.sv
// Bench for safe_input_arbiter: directed session scenarios followed by random traffic,
// all checked cycle by cycle against a session-level reference model.
module tb_safe_input_arbiter;
  localparam int N  = 3;
  localparam int W  = 4;
  localparam int TO = 8;

  logic         clk_i = 1'b0;
  logic         arst_n_i;
  logic [N-1:0] grant_o;
  logic         busy_o;
  logic         timeout_o;

  safe_input_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  safe_input_arbiter #(.N_REQ(N), .DATA_W(W), .IDLE_TIMEOUT(TO)) dut (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .bus       (bus),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  int to_seen = 0;

  // Requester-side stimulus: a pending beat is held until it is accepted.
  bit           pend_v [N];
  logic [W-1:0] pend_d [N];
  bit           pend_l [N];
  int           quiet  [N];
  bit           hs     [N];
  bit           rdy;

  // Reference model: who owns the port, whose turn is next, idle cycles so far.
  int m_owner;
  int m_rr;
  int m_idle;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = N - 1;
    m_idle  = 0;
    m_to    = 1'b0;
    for (int i = 0; i < N; i++) hs[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [W-1:0] d, input bit l);
    pend_v[i] = v;
    pend_d[i] = d;
    pend_l[i] = l;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]         = pend_v[i];
      bus.req_last_i[i]          = pend_l[i];
      bus.req_data_i[i*W +: W]   = pend_d[i];
    end
    bus.data_in_ready_i = rdy;
  endtask

  // One clock: drive, compare against model, advance model, wait for next negedge.
  task automatic cycle();
    logic [N-1:0] eg, er;
    logic         ev;
    logic [W-1:0] ed;
    int           o;
    bit           to_n;
    apply();
    #2;
    o  = m_owner;
    eg = '0; er = '0; ev = 1'b0; ed = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      er[o] = rdy;
      ev    = pend_v[o];
      ed    = pend_d[o];
    end
    check("grant",   32'(grant_o),             32'(eg));
    check("busy",    32'(busy_o),              32'(o >= 0));
    check("timeout", 32'(timeout_o),           32'(m_to));
    check("valid",   32'(bus.data_in_valid_o), 32'(ev));
    check("ready",   32'(bus.req_ready_o),     32'(er));
    if (ev) check("data", 32'(bus.data_in_o), 32'(ed));
    if (timeout_o) to_seen++;

    for (int i = 0; i < N; i++) hs[i] = 1'b0;
    to_n = 1'b0;
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (m_owner < 0 && pend_v[c]) begin
          m_owner = c;
          m_idle  = 0;
        end
      end
    end else if (pend_v[o] && rdy) begin
      hs[o]  = 1'b1;
      m_idle = 0;
      if (pend_l[o]) begin
        m_rr    = o;
        m_owner = -1;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        to_n    = 1'b1;
        m_rr    = o;
        m_owner = -1;
      end
    end
    m_to = to_n;
    for (int i = 0; i < N; i++) if (hs[i]) pend_v[i] = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i]) begin
        if (hs[i] && $urandom_range(0, 3) == 0) quiet[i] = $urandom_range(4, 14);
        if (quiet[i] > 0) quiet[i]--;
        else if ($urandom_range(0, 2) != 0)
          set_req(i, 1'b1, W'($urandom), $urandom_range(0, 4) == 0);
      end
    end
    rdy = ($urandom_range(0, 4) != 0);
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    rdy = 1'b1;
    repeat (TO + 3) cycle();
  endtask

  initial begin
    int to_before;
    arst_n_i = 1'b0;
    rdy      = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, '0, 1'b0);
      quiet[i] = 0;
    end
    model_reset();
    apply();
    #1;
    check("rst_grant",   32'(grant_o),             0);
    check("rst_busy",    32'(busy_o),              0);
    check("rst_timeout", 32'(timeout_o),           0);
    check("rst_valid",   32'(bus.data_in_valid_o), 0);
    check("rst_ready",   32'(bus.req_ready_o),     0);
    @(negedge clk_i);
    arst_n_i = 1'b1;

    // Two contenders after reset: req0 first, then req1 on the next round.
    rdy = 1'b1;
    set_req(0, 1'b1, 4'hA, 1'b1);
    set_req(1, 1'b1, 4'hB, 1'b1);
    cycle();
    cycle();
    set_req(0, 1'b1, 4'hC, 1'b1);
    cycle();
    #1 check("rr_req1_next", 32'(grant_o), 32'h2);
    repeat (4) cycle();
    drain();

    // Single-source 4-symbol session with a 3-cycle stall in the middle.
    set_req(0, 1'b1, 4'd1, 1'b0);
    cycle();
    for (int s = 1; s <= 4; s++) begin
      set_req(0, 1'b1, W'(s), s == 4);
      if (s == 2) begin
        rdy = 1'b0;
        repeat (3) cycle();
        rdy = 1'b1;
      end
      cycle();
    end
    #1 check("sess_closed", 32'(busy_o), 0);
    drain();

    // Owner goes silent: one timeout pulse, then the waiting req1 takes over.
    to_before = to_seen;
    set_req(0, 1'b1, 4'd5, 1'b0);
    cycle();
    cycle();
    set_req(0, 1'b1, 4'd6, 1'b0);
    cycle();
    set_req(1, 1'b1, 4'd9, 1'b1);
    repeat (TO + 4) cycle();
    check("timeout_pulses", 32'(to_seen - to_before), 1);
    drain();

    // Handshake on the last idle cycle rescues the session.
    to_before = to_seen;
    set_req(0, 1'b1, 4'd3, 1'b0);
    cycle();
    cycle();
    repeat (TO - 1) cycle();
    set_req(0, 1'b1, 4'd4, 1'b0);
    cycle();
    #1 check("rescue_busy", 32'(busy_o), 1);
    set_req(0, 1'b1, 4'd7, 1'b1);
    cycle();
    check("rescue_no_timeout", 32'(to_seen - to_before), 0);
    drain();

    // Asynchronous reset in the middle of a session.
    rdy = 1'b0;
    set_req(2, 1'b1, 4'hE, 1'b0);
    cycle();
    cycle();
    #3 arst_n_i = 1'b0;
    #1;
    check("arst_grant", 32'(grant_o),             0);
    check("arst_busy",  32'(busy_o),              0);
    check("arst_valid", 32'(bus.data_in_valid_o), 0);
    check("arst_ready", 32'(bus.req_ready_o),     0);
    model_reset();
    @(negedge clk_i);
    arst_n_i = 1'b1;
    rdy = 1'b1;
    set_req(0, 1'b1, 4'h1, 1'b1);
    cycle();
    #1 check("arst_req0_prio", 32'(grant_o), 32'h1);
    drain();

    repeat (2500) begin
      gen_random();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
